// File: rtl/micro_pkg.sv
// Shared definitions for the microprocessor pipeline: opcodes, NOP encoding,
// fetch FSM states and the upper-immediate decode helper.
package micro_pkg;

    localparam logic [6:0]  OP_LUI    = 7'b0110111;
    localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        KILL  = 2'd2
    } fetch_state_e;

    // True for the U-type opcodes whose immediate lives in instr[31:12].
    function automatic logic is_upper_imm(input logic [6:0] opcode);
        return (opcode == OP_LUI) || (opcode == OP_AUIPC);
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for an instruction that arrived while the fetch
// output register was occupied and stalled. Priority: flush > load > drain.
module fetch_skid_buffer
    import micro_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load_i,
    input  logic        drain_i,
    input  logic        flush_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] instr_i,
    output logic        valid_o,
    output logic        valid_d_o,
    output logic [31:0] pc_o,
    output logic [31:0] instr_o
);

    logic        valid_q, valid_d;
    logic [31:0] pc_q, pc_d;
    logic [31:0] instr_q, instr_d;

    // Next-state selection for the single entry.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (drain_i) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end
    end

    // Entry storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            pc_q    <= 32'h0000_0000;
            instr_q <= NOP_INSTR;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

    assign valid_o   = valid_q;
    assign valid_d_o = valid_d;
    assign pc_o      = pc_q;
    assign instr_o   = instr_q;

endmodule

// File: rtl/unidad_fetch.sv
// Instruction fetch stage: PC, single-outstanding imem reads, output register
// plus skid under stall/redirect. Optional counters with UNIDAD_FETCH_PERF_EN.
module unidad_fetch
    import micro_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [19:0] inmediato,
    output logic        ImnSrc
`ifdef UNIDAD_FETCH_PERF_EN
    ,
    output logic [31:0] cnt_fetched,
    output logic [31:0] cnt_stall
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  addr_q, addr_d;
    logic         req_q, req_d;

    logic         if_valid_q, if_valid_d;
    logic [31:0]  if_pc_q, if_pc_d;
    logic [31:0]  if_instr_q, if_instr_d;

    logic         skid_valid_s, skid_valid_d_s;
    logic [31:0]  skid_pc_s, skid_instr_s;

    logic ack_s, consume_s, acc_s, out_free_s;
    logic out_from_skid_s, out_from_ack_s, skid_load_s;

    // Handshake qualifiers; an ack without an open request is ignored.
    always_comb begin
        ack_s           = req_q && imem_ack;
        consume_s       = if_valid_q && !stall;
        acc_s           = (state_q == FETCH) && ack_s && !redirect;
        out_free_s      = !if_valid_q || consume_s;
        out_from_skid_s = out_free_s && skid_valid_s;
        out_from_ack_s  = out_free_s && !skid_valid_s && acc_s;
        skid_load_s     = acc_s && !out_from_ack_s;
    end

    fetch_skid_buffer u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .load_i    (skid_load_s),
        .drain_i   (out_from_skid_s),
        .flush_i   (redirect),
        .pc_i      (addr_q),
        .instr_i   (imem_rdata),
        .valid_o   (skid_valid_s),
        .valid_d_o (skid_valid_d_s),
        .pc_o      (skid_pc_s),
        .instr_o   (skid_instr_s)
    );

    // FSM, PC and request next-state. The request register looks ahead at the
    // skid so that no ack can ever arrive with nowhere to put it.
    always_comb begin
        state_d = state_q;
        if (redirect) begin
            pc_d = redirect_pc;
        end else if (acc_s) begin
            pc_d = pc_q + 32'd4;
        end else begin
            pc_d = pc_q;
        end

        case (state_q)
            IDLE:    state_d = FETCH;
            FETCH:   state_d = (redirect && req_q && !imem_ack) ? KILL : FETCH;
            KILL:    state_d = ack_s ? FETCH : KILL;
            default: state_d = IDLE;
        endcase

        case (state_d)
            FETCH:   req_d = !skid_valid_d_s;
            KILL:    req_d = 1'b1;
            default: req_d = 1'b0;
        endcase

        // A killed request keeps its original address until its response lands.
        if (state_d == KILL) begin
            addr_d = addr_q;
        end else begin
            addr_d = pc_d;
        end
    end

    // Fetch FSM with registered memory-side outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= RESET_PC;
            req_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            req_q   <= req_d;
        end
    end

    // Output register refill: skid first (older), then a fresh ack.
    always_comb begin
        if_valid_d = if_valid_q;
        if_pc_d    = if_pc_q;
        if_instr_d = if_instr_q;
        if (redirect) begin
            if_valid_d = 1'b0;
        end else if (out_from_skid_s) begin
            if_valid_d = 1'b1;
            if_pc_d    = skid_pc_s;
            if_instr_d = skid_instr_s;
        end else if (out_from_ack_s) begin
            if_valid_d = 1'b1;
            if_pc_d    = addr_q;
            if_instr_d = imem_rdata;
        end else if (consume_s) begin
            if_valid_d = 1'b0;
        end else begin
            if_valid_d = if_valid_q;
        end
    end

    // Decode-side output register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_valid_q <= 1'b0;
            if_pc_q    <= 32'h0000_0000;
            if_instr_q <= NOP_INSTR;
        end else begin
            if_valid_q <= if_valid_d;
            if_pc_q    <= if_pc_d;
            if_instr_q <= if_instr_d;
        end
    end

    assign imem_req  = req_q;
    assign imem_addr = addr_q;
    assign if_valid  = if_valid_q;
    assign if_pc     = if_pc_q;
    assign if_instr  = if_instr_q;
    assign inmediato = if_instr_q[31:12];
    assign ImnSrc    = is_upper_imm(if_instr_q[6:0]);

`ifdef UNIDAD_FETCH_PERF_EN
    logic [31:0] cnt_fetched_q, cnt_fetched_d;
    logic [31:0] cnt_stall_q, cnt_stall_d;

    // Performance counter next values; both wrap naturally.
    always_comb begin
        if (if_valid_q && !stall && !redirect) begin
            cnt_fetched_d = cnt_fetched_q + 32'd1;
        end else begin
            cnt_fetched_d = cnt_fetched_q;
        end
        if (if_valid_q && stall) begin
            cnt_stall_d = cnt_stall_q + 32'd1;
        end else begin
            cnt_stall_d = cnt_stall_q;
        end
    end

    // Performance counter storage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_fetched_q <= 32'h0000_0000;
            cnt_stall_q   <= 32'h0000_0000;
        end else begin
            cnt_fetched_q <= cnt_fetched_d;
            cnt_stall_q   <= cnt_stall_d;
        end
    end

    assign cnt_fetched = cnt_fetched_q;
    assign cnt_stall   = cnt_stall_q;
`endif

endmodule

// File: tb/tb_unidad_fetch.sv
// Directed bench for unidad_fetch: streaming, stall/skid, redirect kill,
// redirect with ack, immediate decode and mid-request reset.
module tb_unidad_fetch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [19:0] inmediato;
    logic        ImnSrc;
`ifdef UNIDAD_FETCH_PERF_EN
    logic [31:0] cnt_fetched;
    logic [31:0] cnt_stall;
`endif

    logic        mem_auto;
    logic        ack_man;
    logic [31:0] rdata_man;
    int          n_tests = 0;
    int          n_fail  = 0;

    always #5 clk = ~clk;

    // Zero-wait memory in auto mode, hand-driven responses otherwise.
    assign imem_ack   = mem_auto ? imem_req : ack_man;
    assign imem_rdata = mem_auto ? (imem_addr ^ 32'hA5A5_0000) : rdata_man;

    unidad_fetch dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .if_valid    (if_valid),
        .if_pc       (if_pc),
        .if_instr    (if_instr),
        .inmediato   (inmediato),
        .ImnSrc      (ImnSrc)
`ifdef UNIDAD_FETCH_PERF_EN
        ,
        .cnt_fetched (cnt_fetched),
        .cnt_stall   (cnt_stall)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        mem_auto = 1'b0; ack_man = 1'b0; rdata_man = 32'h0;
        tick(); tick();
        chk1 ("rst_req",    imem_req, 1'b0);
        chk32("rst_addr",   imem_addr, 32'h0);
        chk1 ("rst_valid",  if_valid, 1'b0);
        chk32("rst_pc",     if_pc, 32'h0);
        chk32("rst_instr",  if_instr, 32'h0000_0013);
        chk32("rst_imm",    {12'd0, inmediato}, 32'h0);
        chk1 ("rst_imnsrc", ImnSrc, 1'b0);
`ifdef UNIDAD_FETCH_PERF_EN
        chk32("rst_cntf", cnt_fetched, 32'h0);
        chk32("rst_cnts", cnt_stall, 32'h0);
`endif

        // Streaming with zero-wait memory.
        rst_n = 1'b1; mem_auto = 1'b1;
        chk1("idle_req", imem_req, 1'b0);
        tick();
        chk1 ("first_req",   imem_req, 1'b1);
        chk32("first_addr",  imem_addr, 32'h0);
        chk1 ("first_valid", if_valid, 1'b0);
        tick();
        chk1 ("s0_valid", if_valid, 1'b1);
        chk32("s0_pc",    if_pc, 32'h0);
        chk32("s0_instr", if_instr, 32'hA5A5_0000);
        chk32("s0_addr",  imem_addr, 32'h4);
        tick();
        chk32("s1_pc",    if_pc, 32'h4);
        chk32("s1_instr", if_instr, 32'hA5A5_0004);
        tick();
        chk32("s2_pc",    if_pc, 32'h8);
        tick();
        chk32("s3_pc",    if_pc, 32'hC);
        chk32("s3_addr",  imem_addr, 32'h10);

        // Stall for 6 cycles: pc 16 goes to the skid, then requests stop.
        stall = 1'b1;
        tick();
        chk32("st_pc",   if_pc, 32'hC);
        chk1 ("st_req",  imem_req, 1'b0);
        chk32("st_addr", imem_addr, 32'h14);
        repeat (5) tick();
        chk32("st_pc_hold",  if_pc, 32'hC);
        chk1 ("st_req_hold", imem_req, 1'b0);
        stall = 1'b0;
        tick();
        chk32("rel_pc",    if_pc, 32'h10);
        chk32("rel_instr", if_instr, 32'hA5A5_0010);
        chk1 ("rel_req",   imem_req, 1'b1);
        chk32("rel_addr",  imem_addr, 32'h14);
`ifdef UNIDAD_FETCH_PERF_EN
        chk32("cnt_stall",   cnt_stall, 32'd6);
        chk32("cnt_fetched", cnt_fetched, 32'd4);
`endif
        tick();
        chk32("rel2_pc",    if_pc, 32'h14);
        chk32("rel2_instr", if_instr, 32'hA5A5_0014);
        chk32("rel2_addr",  imem_addr, 32'h18);

        // Redirect while the request for 0x18 is outstanding.
        mem_auto = 1'b0; ack_man = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h0000_0100;
        tick();
        redirect = 1'b0;
        chk1 ("kill_valid", if_valid, 1'b0);
        chk1 ("kill_req",   imem_req, 1'b1);
        chk32("kill_addr",  imem_addr, 32'h18);
        tick(); tick();
        chk32("kill_addr_hold", imem_addr, 32'h18);
        ack_man = 1'b1; rdata_man = 32'hDEAD_BEEF;
        tick();
        ack_man = 1'b0;
        chk1 ("refetch_valid", if_valid, 1'b0);
        chk1 ("refetch_req",   imem_req, 1'b1);
        chk32("refetch_addr",  imem_addr, 32'h100);
        tick();
        chk1("refetch_wait_valid", if_valid, 1'b0);
        ack_man = 1'b1; rdata_man = 32'h1234_5037;
        tick();
        chk1 ("lui_valid",  if_valid, 1'b1);
        chk32("lui_pc",     if_pc, 32'h100);
        chk32("lui_instr",  if_instr, 32'h1234_5037);
        chk32("lui_imm",    {12'd0, inmediato}, 32'h0001_2345);
        chk1 ("lui_imnsrc", ImnSrc, 1'b1);
        chk32("lui_addr",   imem_addr, 32'h104);

        rdata_man = 32'h00A0_0093;
        tick();
        chk32("addi_pc",     if_pc, 32'h104);
        chk32("addi_imm",    {12'd0, inmediato}, 32'h0000_0A00);
        chk1 ("addi_imnsrc", ImnSrc, 1'b0);

        // Redirect coinciding with an ack while decode is stalled.
        stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h0000_0200;
        rdata_man = 32'hBAD0_BAD0;
        tick();
        stall = 1'b0; redirect = 1'b0; ack_man = 1'b0;
        chk1 ("rdack_valid", if_valid, 1'b0);
        chk1 ("rdack_req",   imem_req, 1'b1);
        chk32("rdack_addr",  imem_addr, 32'h200);
        ack_man = 1'b1; rdata_man = 32'h0000_0213;
        tick();
        ack_man = 1'b0;
        chk32("rd_pc",    if_pc, 32'h200);
        chk32("rd_instr", if_instr, 32'h0000_0213);
        tick();
        chk1 ("rd_drain_valid", if_valid, 1'b0);
        chk32("rd_drain_addr",  imem_addr, 32'h204);
        ack_man = 1'b1; rdata_man = 32'h0000_0313;
        tick();
        ack_man = 1'b0; stall = 1'b1;
        chk1 ("pre_rst_valid", if_valid, 1'b1);
        chk32("pre_rst_pc",    if_pc, 32'h204);
        chk1 ("pre_rst_req",   imem_req, 1'b1);

        // Asynchronous reset in the middle of an open request.
        #2 rst_n = 1'b0;
        #1;
        chk1 ("arst_req",   imem_req, 1'b0);
        chk1 ("arst_valid", if_valid, 1'b0);
        chk32("arst_addr",  imem_addr, 32'h0);
        chk32("arst_instr", if_instr, 32'h0000_0013);
        stall = 1'b0;
        tick();
        rst_n = 1'b1; mem_auto = 1'b1;
        tick();
        chk1 ("rs_req",  imem_req, 1'b1);
        chk32("rs_addr", imem_addr, 32'h0);
        tick();
        chk1 ("rs_valid", if_valid, 1'b1);
        chk32("rs_pc",    if_pc, 32'h0);
        chk32("rs_instr", if_instr, 32'hA5A5_0000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
